data_ram_arbiter: RTL and testbench
===================================

// Module: data_ram_arbiter
// PURPOSE
//  Shares the single data_ram port between two requesters: m0 = CPU memory stage, m1 = DMA/debug port.
//  Arbitrates per cycle and registers the winning command onto the RAM port one cycle after grant.
//  Captures RAM read data and returns it to the owning requester with a valid pulse.
//  Sits between the mem stage/DMA engine and data_ram; pipelined, one access per cycle.
// PARAMETERS
//  AW        32  address width (RAM uses addr[11:2] as word index)
//  DW        32  data width; byte select width is DW/8
//  PRIO_M0   0   0 = round-robin between m0/m1; 1 = fixed priority, m0 always wins
//  LOCK_MAX  16  max consecutive grants held under lock (only with DATA_RAM_ARB_LOCK_EN)
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     asynchronous, active-low reset
//  mX_req     in   1     request valid (X=0,1); held with fields stable until mX_gnt
//  mX_we      in   1     1 = write, 0 = read
//  mX_addr    in   AW    byte address
//  mX_sel     in   DW/8  byte lane enables
//  mX_wdata   in   DW    write data
//  mX_lock    in   1     keep ownership after this grant (ignored without macro)
//  mX_gnt     out  1     request accepted this cycle (combinational from req + arb state)
//  mX_rvalid  out  1     one-cycle pulse: mX_rdata valid
//  mX_rdata   out  DW    read data, held until next mX_rvalid
//  ram_en     out  1     RAM enable
//  ram_we     out  1     RAM write enable
//  ram_re     out  1     RAM read enable
//  ram_addr   out  AW    RAM address
//  ram_sel    out  DW/8  RAM byte select
//  ram_wdata  out  DW    RAM write data
//  ram_rdata  in   DW    RAM read data (combinational from ram_addr)
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer = m0 next; cmd stage empty; FSM = IDLE; lock counter 0.
//  Cycle N: at most one gnt asserted; winning fields latched into cmd register at posedge.
//  Cycle N+1: cmd register drives ram_*; ram_en=1, ram_we=cmd.we, ram_re=~cmd.we. Write commits at end of N+1.
//  Read: ram_rdata sampled at end of N+1; owner's rvalid=1 in cycle N+2, rdata updated. Writes give no rvalid.
//  Empty cmd stage: ram_en=ram_we=ram_re=0, ram_addr/sel/wdata=0.
//  Throughput 1 access/cycle; back-to-back grants allowed, including to the same requester.
//  Both req same cycle: PRIO_M0=1 -> m0; else rr pointer owner wins, pointer moves to the loser after each grant.
//  Single req: granted immediately regardless of pointer; pointer updated as above.
//  Write with sel=0: granted, issued with ram_we=1, no byte changes. addr[1:0] passed through, ignored by RAM.
//  Read-after-write to same word from either requester in consecutive cycles returns the new data (write commits first).
//  FSM: IDLE (no cmd) <-> ACTIVE (cmd issued this cycle); LOCKED only with macro. IDLE->ACTIVE on any gnt; ACTIVE->IDLE when no gnt.
//  Reset mid-operation: pending cmd and pending rvalid discarded; no RAM write occurs after rst falls.
// CONFIGURATION
//  DATA_RAM_ARB_LOCK_EN defined: grant with mX_lock=1 enters LOCKED; only owner eligible while lock held,
//   up to LOCK_MAX consecutive grants; exits on owner grant with lock=0, owner idle 1 cycle, or count=LOCK_MAX.
//   On forced exit the pointer moves to the other requester.
//  Not defined: mX_lock ignored, LOCKED state and counter absent, pure per-cycle arbitration.
// STRUCTURE
//  Shared header define.v: RegWidth/ByteWidth reuse; add ArbStateWidth, ARB_IDLE/ARB_ACTIVE/ARB_LOCKED, ArbOwnerWidth.
//  Sub-module arb_rr2: 2-way round-robin/fixed-priority picker (req[1:0], ptr, prio -> gnt[1:0]); rest in top.
// TESTING
//  Reset: hold rst=0 with reqs high -> no gnt, ram_en=0, rvalid=0; release -> first gnt to m0.
//  m0 write addr 0x10 sel 4'hF data 0xDEADBEEF, then m0 read 0x10 -> rvalid at gnt+2, rdata 0xDEADBEEF.
//  Both reqs high 4 cycles, PRIO_M0=0 -> grants m0,m1,m0,m1; PRIO_M0=1 -> m0 x4, m1 starved.
//  Byte write sel 4'b0100 data 0x00AB0000 on word 0x11223344 -> read returns 0x11AB3344.
//  rst low in cycle after gnt of write 0x20 -> word 0x20 unchanged, no rvalid after release.
//  LOCK_EN: m1 lock=1 for 20 reqs with m0 waiting -> m1 gets 16 grants, then m0 granted.

Source files
------------

// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and widths for the data RAM arbiter.
// Contents: register/byte widths, arbiter state encoding, owner width,
//           command payload struct and an owner helper.
package data_ram_arbiter_pkg;

  localparam int unsigned RegWidth      = 32;
  localparam int unsigned ByteWidth     = RegWidth / 8;
  localparam int unsigned ArbStateWidth = 2;
  localparam int unsigned ArbOwnerWidth = 1;

  typedef enum logic [ArbStateWidth-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  // Command held for one cycle between grant and RAM issue.
  typedef struct packed {
    logic                     we;
    logic [ArbOwnerWidth-1:0] owner;
    logic [RegWidth-1:0]      addr;
    logic [ByteWidth-1:0]     sel;
    logic [RegWidth-1:0]      wdata;
  } arb_cmd_t;

  // The requester that is not `o`.
  function automatic logic [ArbOwnerWidth-1:0] other_owner(input logic [ArbOwnerWidth-1:0] o);
    return ~o;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the two requesters (m0 = CPU mem stage, m1 = DMA/debug),
// the arbiter and data_ram.
// Modports: master = requesters + RAM side, slave = arbiter.
interface data_ram_arbiter_if
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned AW = RegWidth,
  parameter int unsigned DW = RegWidth
);
  localparam int unsigned SW = DW / 8;

  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [SW-1:0] m0_sel;
  logic [DW-1:0] m0_wdata, m0_rdata;

  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [SW-1:0] m1_sel;
  logic [DW-1:0] m1_wdata, m1_rdata;

  logic          ram_en, ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [SW-1:0] ram_sel;
  logic [DW-1:0] ram_wdata, ram_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata, m0_lock,
    output m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_lock,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    input  ram_en, ram_we, ram_re, ram_addr, ram_sel, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_lock,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    output ram_en, ram_we, ram_re, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata
  );

endinterface

// File: rtl/data_ram_arbiter_arb_rr2.sv
// Two-way request picker: round-robin by pointer, or fixed m0 priority.
// Ports: i_req[1:0] requests, i_ptr preferred requester on contention,
//        i_prio 1 = m0 always wins, o_gnt_c[1:0] one-hot grant (combinational).
module data_ram_arbiter_arb_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_prio,
  output logic [1:0] o_gnt_c
);

  always_comb begin
    o_gnt_c = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt_c = 2'b01;
      2'b10:   o_gnt_c = 2'b10;
      2'b11:   o_gnt_c = (i_prio || !i_ptr) ? 2'b01 : 2'b10;
      default: o_gnt_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the data_ram port between m0 (CPU mem stage) and m1 (DMA/debug).
// Grant in cycle N, command on ram_* in N+1, read data returned with a
// one-cycle rvalid pulse to the owner in N+2. One access per cycle.
// Ports: i_clk, i_rst (async, active-low), io_bus (slave modport).
// Optional: DATA_RAM_ARB_LOCK_EN enables mX_lock ownership holding for up to
// LOCK_MAX consecutive grants; without it mX_lock is ignored.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned AW       = RegWidth,
  parameter int unsigned DW       = RegWidth,
  parameter bit          PRIO_M0  = 1'b0,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  data_ram_arbiter_if.slave io_bus
);

  localparam int unsigned SW = DW / 8;

  logic [1:0]               w_req, w_req_elig, w_gnt;
  logic                     w_any_gnt;
  logic [ArbOwnerWidth-1:0] w_win;
  arb_cmd_t                 w_win_cmd;

  arb_state_e               r_state, w_state_nxt;
  logic [ArbOwnerWidth-1:0] r_ptr, w_ptr_nxt;

  arb_cmd_t                 r_cmd;
  logic                     r_ram_en, r_ram_re;
  logic [1:0]               r_rvalid;
  logic [DW-1:0]            r_rdata0, r_rdata1;

  // Requests are masked while reset is held so no grant leaks out of reset.
  assign w_req = {io_bus.m1_req, io_bus.m0_req} & {2{i_rst}};

`ifdef DATA_RAM_ARB_LOCK_EN
  localparam int unsigned LockCntW = $clog2(LOCK_MAX + 1);

  logic [LockCntW-1:0]      r_lock_cnt, w_lock_cnt_nxt;
  logic [ArbOwnerWidth-1:0] r_lock_own, w_lock_own_nxt;
  logic                     w_win_lock;

  // Only the lock owner may compete while the lock is held.
  always_comb begin
    w_req_elig = w_req;
    if (r_state == ARB_LOCKED) w_req_elig = w_req & (r_lock_own[0] ? 2'b10 : 2'b01);
  end

  assign w_win_lock = w_win[0] ? io_bus.m1_lock : io_bus.m0_lock;
`else
  logic w_unused;
  assign w_req_elig = w_req;
  assign w_unused   = ^{io_bus.m0_lock, io_bus.m1_lock, 1'(LOCK_MAX)};
`endif

  data_ram_arbiter_arb_rr2 u_arb (
    .i_req  (w_req_elig),
    .i_ptr  (r_ptr[0]),
    .i_prio (PRIO_M0),
    .o_gnt_c(w_gnt)
  );

  assign w_any_gnt     = |w_gnt;
  assign w_win         = ArbOwnerWidth'(w_gnt[1]);
  assign io_bus.m0_gnt = w_gnt[0];
  assign io_bus.m1_gnt = w_gnt[1];

  // Winning requester's fields, captured into r_cmd at the grant edge.
  always_comb begin
    w_win_cmd       = '0;
    w_win_cmd.owner = w_win;
    if (w_win[0]) begin
      w_win_cmd.we    = io_bus.m1_we;
      w_win_cmd.addr  = RegWidth'(io_bus.m1_addr);
      w_win_cmd.sel   = ByteWidth'(io_bus.m1_sel);
      w_win_cmd.wdata = RegWidth'(io_bus.m1_wdata);
    end else begin
      w_win_cmd.we    = io_bus.m0_we;
      w_win_cmd.addr  = RegWidth'(io_bus.m0_addr);
      w_win_cmd.sel   = ByteWidth'(io_bus.m0_sel);
      w_win_cmd.wdata = RegWidth'(io_bus.m0_wdata);
    end
  end

  // Next state: ACTIVE whenever a command is granted; pointer goes to the loser.
  always_comb begin
    w_state_nxt = ARB_IDLE;
    w_ptr_nxt   = r_ptr;
`ifdef DATA_RAM_ARB_LOCK_EN
    w_lock_cnt_nxt = '0;
    w_lock_own_nxt = r_lock_own;
`endif
    if (w_any_gnt) begin
      w_state_nxt = ARB_ACTIVE;
      w_ptr_nxt   = other_owner(w_win);
`ifdef DATA_RAM_ARB_LOCK_EN
      if (r_state == ARB_LOCKED) begin
        // Stay locked until the owner drops lock or the grant budget is spent.
        if (w_win_lock && ((r_lock_cnt + LockCntW'(1)) != LockCntW'(LOCK_MAX))) begin
          w_state_nxt    = ARB_LOCKED;
          w_lock_cnt_nxt = r_lock_cnt + LockCntW'(1);
        end
      end else if (w_win_lock && (LOCK_MAX > 1)) begin
        w_state_nxt    = ARB_LOCKED;
        w_lock_cnt_nxt = LockCntW'(1);
        w_lock_own_nxt = w_win;
      end
`endif
    end
  end

  // Arbitration state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
`ifdef DATA_RAM_ARB_LOCK_EN
      r_lock_cnt <= '0;
      r_lock_own <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
`ifdef DATA_RAM_ARB_LOCK_EN
      r_lock_cnt <= w_lock_cnt_nxt;
      r_lock_own <= w_lock_own_nxt;
`endif
    end
  end

  // Command stage and read-return registers; an empty stage drives all zeros.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cmd    <= '0;
      r_ram_en <= 1'b0;
      r_ram_re <= 1'b0;
      r_rvalid <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_cmd    <= w_any_gnt ? w_win_cmd : '0;
      r_ram_en <= w_any_gnt;
      r_ram_re <= w_any_gnt & ~w_win_cmd.we;
      r_rvalid <= '0;
      if ((r_state != ARB_IDLE) && !r_cmd.we) begin
        if (r_cmd.owner == ArbOwnerWidth'(1)) begin
          r_rvalid[1] <= 1'b1;
          r_rdata1    <= io_bus.ram_rdata;
        end else begin
          r_rvalid[0] <= 1'b1;
          r_rdata0    <= io_bus.ram_rdata;
        end
      end
    end
  end

  assign io_bus.ram_en    = r_ram_en;
  assign io_bus.ram_we    = r_cmd.we;
  assign io_bus.ram_re    = r_ram_re;
  assign io_bus.ram_addr  = AW'(r_cmd.addr);
  assign io_bus.ram_sel   = SW'(r_cmd.sel);
  assign io_bus.ram_wdata = DW'(r_cmd.wdata);

  assign io_bus.m0_rvalid = r_rvalid[0];
  assign io_bus.m1_rvalid = r_rvalid[1];
  assign io_bus.m0_rdata  = r_rdata0;
  assign io_bus.m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Testbench for data_ram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model and a word-array RAM.
module tb_data_ram_arbiter;
  import data_ram_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned NW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_ram_arbiter_if #(.AW(AW), .DW(DW)) bus   ();
  data_ram_arbiter_if #(.AW(AW), .DW(DW)) bus_p ();

  data_ram_arbiter #(.AW(AW), .DW(DW), .PRIO_M0(1'b0), .LOCK_MAX(16)) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus)
  );

  // Fixed-priority variant sees the same requests; only its grants are checked.
  data_ram_arbiter #(.AW(AW), .DW(DW), .PRIO_M0(1'b1), .LOCK_MAX(16)) dut_p (
    .i_clk(clk), .i_rst(rst), .io_bus(bus_p)
  );

  assign bus_p.m0_req = bus.m0_req;    assign bus_p.m1_req = bus.m1_req;
  assign bus_p.m0_we = bus.m0_we;      assign bus_p.m1_we = bus.m1_we;
  assign bus_p.m0_addr = bus.m0_addr;  assign bus_p.m1_addr = bus.m1_addr;
  assign bus_p.m0_sel = bus.m0_sel;    assign bus_p.m1_sel = bus.m1_sel;
  assign bus_p.m0_wdata = bus.m0_wdata; assign bus_p.m1_wdata = bus.m1_wdata;
  assign bus_p.m0_lock = bus.m0_lock;  assign bus_p.m1_lock = bus.m1_lock;
  assign bus_p.ram_rdata = '0;

  // Behavioural data_ram: combinational read, byte-masked write at posedge.
  logic [DW-1:0] ram [NW];
  assign bus.ram_rdata = ram[bus.ram_addr[11:2]];
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we)
      for (int b = 0; b < SW; b++)
        if (bus.ram_sel[b]) ram[bus.ram_addr[11:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester stimulus slots.
  logic          s_req [2];
  logic          s_we  [2];
  logic          s_lock[2];
  logic [AW-1:0] s_addr[2];
  logic [SW-1:0] s_sel [2];
  logic [DW-1:0] s_wd  [2];

  // Reference model state.
  logic [DW-1:0] ref_mem [NW];
  int            ptr;
  bit            pend_vld, pend_we, p_pend;
  int            pend_own;
  logic [AW-1:0] pend_addr;
  logic [SW-1:0] pend_sel;
  logic [DW-1:0] pend_wd;
  bit            exp_rv[2];
  logic [DW-1:0] exp_rd[2];

  // Values observed in the most recent step.
  int m_win;
  bit m_g[2], m_pg[2], m_rv[2];

  task automatic drive();
    bus.m0_req = s_req[0]; bus.m0_we = s_we[0]; bus.m0_addr = s_addr[0];
    bus.m0_sel = s_sel[0]; bus.m0_wdata = s_wd[0]; bus.m0_lock = s_lock[0];
    bus.m1_req = s_req[1]; bus.m1_we = s_we[1]; bus.m1_addr = s_addr[1];
    bus.m1_sel = s_sel[1]; bus.m1_wdata = s_wd[1]; bus.m1_lock = s_lock[1];
  endtask

  task automatic model_reset();
    ptr = 0; pend_vld = 0; pend_we = 0; p_pend = 0; pend_own = 0;
    pend_addr = '0; pend_sel = '0; pend_wd = '0;
    for (int k = 0; k < 2; k++) begin exp_rv[k] = 0; exp_rd[k] = '0; end
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (!v) model_reset();
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One clock: check outputs at negedge, advance the model at posedge.
  task automatic step();
    int win, pwin;
    @(negedge clk);
    if (!rst)                      win = -1;
    else if (s_req[0] && s_req[1]) win = ptr;
    else if (s_req[0])             win = 0;
    else if (s_req[1])             win = 1;
    else                           win = -1;
    pwin = !rst ? -1 : (s_req[0] ? 0 : (s_req[1] ? 1 : -1));
    m_win = win;
    m_g[0] = bus.m0_gnt; m_g[1] = bus.m1_gnt;
    m_pg[0] = bus_p.m0_gnt; m_pg[1] = bus_p.m1_gnt;
    m_rv[0] = bus.m0_rvalid; m_rv[1] = bus.m1_rvalid;
    check_eq("m0_gnt", bus.m0_gnt, win == 0);
    check_eq("m1_gnt", bus.m1_gnt, win == 1);
    check_eq("prio_m0_gnt", bus_p.m0_gnt, pwin == 0);
    check_eq("prio_m1_gnt", bus_p.m1_gnt, pwin == 1);
    check_eq("prio_ram_en", bus_p.ram_en, p_pend);
    check_eq("ram_en", bus.ram_en, pend_vld);
    check_eq("ram_we", bus.ram_we, pend_vld && pend_we);
    check_eq("ram_re", bus.ram_re, pend_vld && !pend_we);
    check_eq("ram_addr", bus.ram_addr, pend_vld ? pend_addr : '0);
    check_eq("ram_sel", bus.ram_sel, pend_vld ? pend_sel : '0);
    check_eq("ram_wdata", bus.ram_wdata, pend_vld ? pend_wd : '0);
    check_eq("m0_rvalid", bus.m0_rvalid, exp_rv[0]);
    check_eq("m1_rvalid", bus.m1_rvalid, exp_rv[1]);
    check_eq("m0_rdata", bus.m0_rdata, exp_rd[0]);
    check_eq("m1_rdata", bus.m1_rdata, exp_rd[1]);
    @(posedge clk);
    if (rst) begin
      exp_rv[0] = 0; exp_rv[1] = 0;
      if (pend_vld && !pend_we) begin
        exp_rv[pend_own] = 1;
        exp_rd[pend_own] = ref_mem[pend_addr[11:2]];
      end
      if (pend_vld && pend_we)
        ref_mem[pend_addr[11:2]] = merge(ref_mem[pend_addr[11:2]], pend_wd, pend_sel);
      pend_vld = (win >= 0);
      if (win >= 0) begin
        pend_own = win; pend_we = s_we[win]; pend_addr = s_addr[win];
        pend_sel = s_sel[win]; pend_wd = s_wd[win];
        ptr = 1 - win;
      end
      p_pend = (pwin >= 0);
    end
    #1;
  endtask

  task automatic do_txn(input int k, input bit we, input logic [AW-1:0] a,
                        input logic [SW-1:0] s, input logic [DW-1:0] d);
    int n;
    n = 0;
    s_req[k] = 1; s_we[k] = we; s_addr[k] = a; s_sel[k] = s; s_wd[k] = d; s_lock[k] = 0;
    drive();
    do begin step(); n++; end while (!m_g[k] && n < 20);
    check_eq("txn_granted", m_g[k], 1);
    s_req[k] = 0;
    drive();
  endtask

  task automatic wait_rvalid(input int k);
    int n;
    n = 0;
    do begin step(); n++; end while (!m_rv[k] && n < 6);
    check_eq("rvalid_seen", m_rv[k], 1);
  endtask

  task automatic new_txn(input int k);
    s_req[k]  = 1;
    s_we[k]   = 1'($urandom);
    s_addr[k] = {20'($urandom), 7'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
    s_sel[k]  = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom);
    s_wd[k]   = $urandom;
    s_lock[k] = 1'($urandom);
  endtask

  logic [DW-1:0] orig;

  initial begin
    for (int i = 0; i < NW; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    for (int k = 0; k < 2; k++) begin
      s_req[k] = 1; s_we[k] = 0; s_lock[k] = 0; s_sel[k] = 4'hF; s_wd[k] = '0;
    end
    s_addr[0] = 32'h0000_0100; s_addr[1] = 32'h0000_0104;
    drive();
    set_rst(1'b0);

    // Held in reset with both requests high: nothing may be granted.
    repeat (3) begin
      step();
      check_eq("rst_no_gnt", m_g[0] | m_g[1], 0);
    end
    set_rst(1'b1);

    // Contention right after reset alternates m0,m1,m0,m1; fixed priority starves m1.
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rr_m0", m_g[0], (i % 2) == 0);
      check_eq("rr_m1", m_g[1], (i % 2) == 1);
      check_eq("prio_m1_starved", m_pg[1], 0);
    end
    s_req[0] = 0; s_req[1] = 0;
    drive();
    repeat (3) step();

    // Write then read back; data returns two cycles after the read grant.
    do_txn(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    do_txn(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    step();
    check_eq("rvalid_not_n1", m_rv[0], 0);
    step();
    check_eq("rvalid_at_n2", m_rv[0], 1);
    check_eq("read_back", bus.m0_rdata, 32'hDEAD_BEEF);

    // Single byte lane update, then a sel=0 write that must change nothing.
    do_txn(1, 1'b1, 32'h0000_0040, 4'hF, 32'h1122_3344);
    do_txn(1, 1'b1, 32'h0000_0040, 4'b0100, 32'h00AB_0000);
    do_txn(0, 1'b1, 32'h0000_0043, 4'h0, 32'hFFFF_FFFF);
    do_txn(1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
    wait_rvalid(1);
    check_eq("byte_write", bus.m1_rdata, 32'h11AB_3344);

    // Reset lands while the write to 0x20 is on the RAM port: write is dropped.
    orig = ref_mem[8];
    do_txn(0, 1'b1, 32'h0000_0020, 4'hF, 32'hCAFE_F00D);
    set_rst(1'b0);
    step();
    check_eq("rst_ram_we", bus.ram_we, 0);
    step();
    set_rst(1'b1);
    repeat (3) begin
      step();
      check_eq("rst_no_rvalid", m_rv[0] | m_rv[1], 0);
    end
    do_txn(0, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
    wait_rvalid(0);
    check_eq("rst_word_kept", bus.m0_rdata, orig);

    // Randomized two-requester traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) set_rst(1'b0);
      else if (!rst && $urandom_range(0, 2) == 0) set_rst(1'b1);
      step();
      for (int k = 0; k < 2; k++) begin
        if (m_win == k || !s_req[k]) begin
          if ($urandom_range(0, 99) < 70) new_txn(k);
          else s_req[k] = 0;
        end
      end
      drive();
    end
    set_rst(1'b1);
    s_req[0] = 0; s_req[1] = 0;
    drive();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
